uart_block_loader: RTL and testbench



---
 rtl/uart_block_loader.sv | 189 ++++++++++++++++++
 tb/tb_uart_block_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_block_loader.sv
// UART packet parser producing (x,y,z,type) block writes for the L3 cache.
// Optional checksum byte is enabled by defining UART_BLOCK_LOADER_CHECKSUM_EN.
module uart_block_loader #(
    parameter int          LENGTH         = 64,
    parameter int          WIDTH          = 64,
    parameter int          HEIGHT         = 16,
    parameter int          BLOCK_W        = 5,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 10_000
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [7:0]                  data_byte_in,
    input  logic                        new_data_in,
    output logic                        wr_valid_out,
    input  logic                        wr_ready_in,
    output logic [$clog2(LENGTH)-1:0]   wr_x_out,
    output logic [$clog2(WIDTH)-1:0]    wr_y_out,
    output logic [$clog2(HEIGHT)-1:0]   wr_z_out,
    output logic [BLOCK_W-1:0]          wr_block_out,
    output logic                        busy_out,
    output logic                        err_out,
    output logic [1:0]                  err_code_out,
    output logic [15:0]                 pkt_count_out
);

    localparam int XW = $clog2(LENGTH);
    localparam int YW = $clog2(WIDTH);
    localparam int ZW = $clog2(HEIGHT);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_X    = 3'd1,
        S_Y    = 3'd2,
        S_Z    = 3'd3,
`ifdef UART_BLOCK_LOADER_CHECKSUM_EN
        S_CHK  = 3'd5,
`endif
        S_TYPE = 3'd4
    } state_t;

    state_t            state_r, state_n_s;
    logic [7:0]        x_r, y_r, z_r, type_r;
    logic [TW-1:0]     tmo_r;
    logic              wr_valid_r, err_r;
    logic [XW-1:0]     wr_x_r;
    logic [YW-1:0]     wr_y_r;
    logic [ZW-1:0]     wr_z_r;
    logic [BLOCK_W-1:0] wr_block_r;
    logic [1:0]        err_code_r, err_code_s;
    logic [15:0]       pkt_count_r;
    logic              busy_s, last_s, tmo_s, chk_ok_s, range_ok_s, free_s, commit_s, err_s;
    logic [7:0]        type_s;

    assign busy_s = (state_r != S_SYNC);

    // Next-state decode, final-byte detection and idle timeout
    always_comb begin
        state_n_s = state_r;
        last_s    = 1'b0;
        tmo_s     = 1'b0;
        chk_ok_s  = 1'b1;
        type_s    = type_r;
        case (state_r)
            S_SYNC: begin
                if (new_data_in && (data_byte_in == SYNC_BYTE)) state_n_s = S_X;
                else                                            state_n_s = S_SYNC;
            end
            S_X: begin
                if (new_data_in) state_n_s = S_Y;
                else             state_n_s = S_X;
            end
            S_Y: begin
                if (new_data_in) state_n_s = S_Z;
                else             state_n_s = S_Y;
            end
            S_Z: begin
                if (new_data_in) state_n_s = S_TYPE;
                else             state_n_s = S_Z;
            end
`ifdef UART_BLOCK_LOADER_CHECKSUM_EN
            S_TYPE: begin
                if (new_data_in) state_n_s = S_CHK;
                else             state_n_s = S_TYPE;
            end
            S_CHK: begin
                if (new_data_in) begin
                    state_n_s = S_SYNC;
                    last_s    = 1'b1;
                    chk_ok_s  = (data_byte_in == (x_r ^ y_r ^ z_r ^ type_r));
                end else begin
                    state_n_s = S_CHK;
                end
            end
`else
            S_TYPE: begin
                if (new_data_in) begin
                    state_n_s = S_SYNC;
                    last_s    = 1'b1;
                    type_s    = data_byte_in;
                end else begin
                    state_n_s = S_TYPE;
                end
            end
`endif
            default: state_n_s = S_SYNC;
        endcase
        // An arriving byte always beats the timeout on the same cycle
        if (busy_s && !new_data_in && (tmo_r == TW'(TIMEOUT_CYCLES - 1))) begin
            state_n_s = S_SYNC;
            tmo_s     = 1'b1;
        end else begin
            tmo_s     = 1'b0;
        end
    end

    // Packet validation, commit decision and error selection
    always_comb begin
        range_ok_s = ({24'd0, x_r} < 32'(LENGTH)) && ({24'd0, y_r} < 32'(WIDTH)) &&
                     ({24'd0, z_r} < 32'(HEIGHT)) && ((type_s >> BLOCK_W) == 8'd0);
        free_s     = !wr_valid_r || wr_ready_in;
        commit_s   = last_s && range_ok_s && chk_ok_s && free_s;
        err_s      = 1'b1;
        err_code_s = err_code_r;
        if (tmo_s) begin
            err_code_s = 2'd2;
        end else if (last_s && !range_ok_s) begin
            err_code_s = 2'd0;
        end else if (last_s && !chk_ok_s) begin
            err_code_s = 2'd1;
        end else if (last_s && !free_s) begin
            err_code_s = 2'd3;
        end else begin
            err_s      = 1'b0;
        end
    end

    // State, field capture, timeout counter and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= S_SYNC;
            x_r         <= 8'd0;
            y_r         <= 8'd0;
            z_r         <= 8'd0;
            type_r      <= 8'd0;
            tmo_r       <= '0;
            wr_valid_r  <= 1'b0;
            wr_x_r      <= '0;
            wr_y_r      <= '0;
            wr_z_r      <= '0;
            wr_block_r  <= '0;
            err_r       <= 1'b0;
            err_code_r  <= 2'd0;
            pkt_count_r <= 16'd0;
        end else begin
            state_r <= state_n_s;
            if (new_data_in && (state_r == S_X))    x_r    <= data_byte_in;
            if (new_data_in && (state_r == S_Y))    y_r    <= data_byte_in;
            if (new_data_in && (state_r == S_Z))    z_r    <= data_byte_in;
            if (new_data_in && (state_r == S_TYPE)) type_r <= data_byte_in;
            if (new_data_in || tmo_s) tmo_r <= '0;
            else if (busy_s)          tmo_r <= tmo_r + TW'(1);
            if (commit_s) begin
                wr_valid_r  <= 1'b1;
                wr_x_r      <= x_r[XW-1:0];
                wr_y_r      <= y_r[YW-1:0];
                wr_z_r      <= z_r[ZW-1:0];
                wr_block_r  <= type_s[BLOCK_W-1:0];
                pkt_count_r <= pkt_count_r + 16'd1;
            end else if (wr_valid_r && wr_ready_in) begin
                wr_valid_r  <= 1'b0;
            end
            err_r      <= err_s;
            err_code_r <= err_code_s;
        end
    end

    assign wr_valid_out  = wr_valid_r;
    assign wr_x_out      = wr_x_r;
    assign wr_y_out      = wr_y_r;
    assign wr_z_out      = wr_z_r;
    assign wr_block_out  = wr_block_r;
    assign busy_out      = busy_s;
    assign err_out       = err_r;
    assign err_code_out  = err_code_r;
    assign pkt_count_out = pkt_count_r;

endmodule

// File: tb/tb_uart_block_loader.sv
// Scoreboard bench for uart_block_loader: expected writes and error codes are
// queued as packets are sent and popped when the DUT produces them.
module tb_uart_block_loader;

    localparam int TMO = 10_000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_byte;
    logic        new_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [5:0]  wr_x;
    logic [5:0]  wr_y;
    logic [3:0]  wr_z;
    logic [4:0]  wr_block;
    logic        busy;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] pkt_count;

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
        logic [3:0] z;
        logic [4:0] b;
    } wr_t;

    wr_t        exp_q[$];
    logic [1:0] err_q[$];
    wr_t        mon_w;
    wr_t        got_w;
    logic [1:0] mon_c;
    int         tests = 0;
    int         fails = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    uart_block_loader dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .data_byte_in  (data_byte),
        .new_data_in   (new_data),
        .wr_valid_out  (wr_valid),
        .wr_ready_in   (wr_ready),
        .wr_x_out      (wr_x),
        .wr_y_out      (wr_y),
        .wr_z_out      (wr_z),
        .wr_block_out  (wr_block),
        .busy_out      (busy),
        .err_out       (err),
        .err_code_out  (err_code),
        .pkt_count_out (pkt_count)
    );

    // Scoreboard monitor: accepted writes and error pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
            tests++;
            got_w = '{x: wr_x, y: wr_y, z: wr_z, b: wr_block};
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write got=%h required=none", got_w);
            end else begin
                mon_w = exp_q.pop_front();
                if (got_w !== mon_w) begin
                    fails++;
                    $display("FAIL write_data got=%h required=%h", got_w, mon_w);
                end
            end
        end
        if (err === 1'b1) begin
            tests++;
            if (err_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_err got code=%0d required=none", err_code);
            end else begin
                mon_c = err_q.pop_front();
                if (err_code !== mon_c) begin
                    fails++;
                    $display("FAIL err_code got=%0d required=%0d", err_code, mon_c);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        data_byte = b;
        new_data  = 1'b1;
        @(posedge clk);
        #2;
        new_data  = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] z, input logic [7:0] t);
        send_byte(8'hA5);
        send_byte(x);
        send_byte(y);
        send_byte(z);
        send_byte(t);
`ifdef UART_BLOCK_LOADER_CHECKSUM_EN
        send_byte(x ^ y ^ z ^ t);
`endif
    endtask

    task automatic exp_write(input logic [7:0] x, input logic [7:0] y,
                             input logic [7:0] z, input logic [7:0] t);
        exp_q.push_back('{x: x[5:0], y: y[5:0], z: z[3:0], b: t[4:0]});
        exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; new_data = 1'b0; data_byte = 8'h00; wr_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        tests++;
        if ({wr_valid, wr_x, wr_y, wr_z, wr_block, err, err_code} !== 26'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h required=0",
                     {wr_valid, wr_x, wr_y, wr_z, wr_block, err, err_code});
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b required=0", busy); end
        tests++;
        if (pkt_count !== 16'd0) begin fails++; $display("FAIL reset_count got=%0d required=0", pkt_count); end
    endtask

    task automatic test_basic;
        wr_ready = 1'b1;
        exp_write(8'h03, 8'h3F, 8'h0F, 8'h07);
        send_pkt(8'h03, 8'h3F, 8'h0F, 8'h07);
        tests++;
        if ({wr_valid, wr_x, wr_y, wr_z, wr_block} !== {1'b1, 6'd3, 6'd63, 4'd15, 5'd7}) begin
            fails++;
            $display("FAIL basic_latency got=%h required=%h",
                     {wr_valid, wr_x, wr_y, wr_z, wr_block}, {1'b1, 6'd3, 6'd63, 4'd15, 5'd7});
        end
        idle(2);
        tests++;
        if (pkt_count !== exp_cnt) begin fails++; $display("FAIL basic_count got=%0d required=%0d", pkt_count, exp_cnt); end
        tests++;
        if (wr_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop got=%b required=0", wr_valid); end
    endtask

    task automatic test_range;
        logic [8:0] tbl [5][4];
        tbl = '{'{9'd63, 9'd63, 9'd15, 9'd31}, '{9'd0, 9'd64, 9'd0, 9'd0},
                '{9'd0, 9'd0, 9'd16, 9'd0},    '{9'd0, 9'd0, 9'd0, 9'd32},
                '{9'd0, 9'd0, 9'd0, 9'd0}};
        send_byte(8'h12);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL junk_busy got=%b required=0", busy); end
        err_q.push_back(2'd0);
        send_pkt(8'h40, 8'h00, 8'h00, 8'h01);
        idle(1);
        tests++;
        if ({busy, wr_valid, err_code} !== 4'b0000) begin
            fails++;
            $display("FAIL range_x got=%b required=0000", {busy, wr_valid, err_code});
        end
        for (int i = 0; i < 5; i++) begin
            if (tbl[i][0] < 9'd64 && tbl[i][1] < 9'd64 && tbl[i][2] < 9'd16 && tbl[i][3] < 9'd32)
                exp_write(tbl[i][0][7:0], tbl[i][1][7:0], tbl[i][2][7:0], tbl[i][3][7:0]);
            else
                err_q.push_back(2'd0);
            send_pkt(tbl[i][0][7:0], tbl[i][1][7:0], tbl[i][2][7:0], tbl[i][3][7:0]);
            idle(2);
        end
        tests++;
        if (pkt_count !== exp_cnt) begin fails++; $display("FAIL range_count got=%0d required=%0d", pkt_count, exp_cnt); end
    endtask

`ifdef UART_BLOCK_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        err_q.push_back(2'd1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04); send_byte(8'hFF);
        idle(2);
        err_q.push_back(2'd0);
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        idle(2);
        exp_write(8'h01, 8'h02, 8'h03, 8'h04);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04); send_byte(8'h04);
        idle(2);
        tests++;
        if (pkt_count !== exp_cnt) begin fails++; $display("FAIL chk_count got=%0d required=%0d", pkt_count, exp_cnt); end
    endtask
`endif

    task automatic test_timeout;
        send_byte(8'hA5);
        send_byte(8'h01);
        idle(TMO - 1);
        tests++;
        if ({busy, err} !== 2'b10) begin fails++; $display("FAIL tmo_early got=%b required=10", {busy, err}); end
        err_q.push_back(2'd2);
        idle(1);
        tests++;
        if ({busy, err, err_code} !== 4'b0110) begin
            fails++;
            $display("FAIL tmo_fire got=%b required=0110", {busy, err, err_code});
        end
        idle(1);
        send_byte(8'hA5);
        idle(TMO - 1);
        exp_write(8'h01, 8'h02, 8'h03, 8'h04);
        send_byte(8'h01);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL tmo_byte_wins got=%b required=1", busy); end
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef UART_BLOCK_LOADER_CHECKSUM_EN
        send_byte(8'h04);
`endif
        idle(2);
        exp_write(8'h05, 8'h06, 8'h07, 8'h08);
        send_pkt(8'h05, 8'h06, 8'h07, 8'h08);
        idle(2);
        tests++;
        if (pkt_count !== exp_cnt) begin fails++; $display("FAIL tmo_count got=%0d required=%0d", pkt_count, exp_cnt); end
    endtask

    task automatic test_back_to_back;
        wr_ready = 1'b0;
        exp_write(8'h01, 8'h02, 8'h03, 8'h04);
        send_pkt(8'h01, 8'h02, 8'h03, 8'h04);
        err_q.push_back(2'd3);
        send_pkt(8'h05, 8'h06, 8'h07, 8'h08);
        idle(3);
        tests++;
        if ({wr_valid, wr_x, wr_y, wr_z, wr_block} !== {1'b1, 6'd1, 6'd2, 4'd3, 5'd4}) begin
            fails++;
            $display("FAIL b2b_hold got=%h required=%h",
                     {wr_valid, wr_x, wr_y, wr_z, wr_block}, {1'b1, 6'd1, 6'd2, 4'd3, 5'd4});
        end
        check("b2b_count", {16'd0, pkt_count}, {16'd0, exp_cnt});
        check("b2b_code", {30'd0, err_code}, 32'd3);
        wr_ready = 1'b1;
        idle(1);
        check("b2b_drop", {31'd0, wr_valid}, 32'd0);
        check("b2b_drained", exp_q.size(), 32'd0);
    endtask

    task automatic test_reset_mid;
        wr_ready = 1'b0;
        send_pkt(8'h09, 8'h09, 8'h09, 8'h09);
        check("mid_pending", {31'd0, wr_valid}, 32'd1);
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h06);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp_cnt = 16'd0;
        check("mid_outputs", {5'd0, wr_valid, wr_x, wr_y, wr_z, wr_block, busy, err, err_code},
              32'd0);
        check("mid_count", {16'd0, pkt_count}, 32'd0);
        wr_ready = 1'b1;
        exp_write(8'h0A, 8'h14, 8'h05, 8'h03);
        send_pkt(8'h0A, 8'h14, 8'h05, 8'h03);
        idle(2);
        check("mid_after_count", {16'd0, pkt_count}, 32'd1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_range();
`ifdef UART_BLOCK_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        idle(3);
        check("queues_empty", exp_q.size() + err_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
